// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    HELD     = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    PAT_NONE  = 2'd0,
    PAT_ONE   = 2'd1,
    PAT_MULTI = 2'd2
  } pat_cls_e;

  localparam logic [3:0] ROW_INIT = 4'b1110;

  // Index of the low bit in a one-hot-low vector; lowest zero wins if malformed.
  function automatic logic [1:0] onehot_lo_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic pat_cls_e pat_class(input logic [3:0] p);
    logic [2:0] n;
    pat_cls_e   cls;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, p[i]};
    if (n == 3'd0)      cls = PAT_NONE;
    else if (n == 3'd1) cls = PAT_ONE;
    else                cls = PAT_MULTI;
    return cls;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_scan_timer.sv
// Free-running modulo-SCAN_DIV slot counter; strobes in the last cycle of each row slot.
module scan_timer #(
  parameter int SCAN_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sample_o
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign sample_o = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = sample_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-sweep keypad scanner with debounce, single-key encode and release hold-off.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] column_in,
  output logic [3:0] row_sweep,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int              DW      = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0]   DEB_MAX = DW'(DEBOUNCE_CNT);

  kp_state_e     state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [1:0]    cand_q, cand_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [3:0]    code_q, code_d;
  logic          held_q, held_d;
  logic          multi_q, multi_d;

  logic          sample;
  pat_cls_e      cls;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [3:0]    row_rot;
  logic [DW-1:0] deb_inc;

  scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .sample_o (sample)
  );

  assign cls     = pat_class(~column_in);
  assign col_idx = onehot_lo_idx(column_in);
  assign row_idx = onehot_lo_idx(row_q);
  assign row_rot = {row_q[2:0], row_q[3]};
  assign deb_inc = deb_q + DW'(1);

  // key_code and key_held are loaded on entry to ACCEPT so they are already
  // valid during the key_valid strobe cycle.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cand_d    = cand_q;
    deb_d     = deb_q;
    code_d    = code_q;
    held_d    = held_q;
    multi_d   = sample ? (cls == PAT_MULTI) : multi_q;
    key_valid = (state_q == ACCEPT);

    case (state_q)
      SCAN: begin
        if (sample) begin
          if (cls == PAT_ONE) begin
            cand_d = col_idx;
            deb_d  = DW'(1);
            if (DEBOUNCE_CNT == 1) begin
              state_d = ACCEPT;
              code_d  = {row_idx, col_idx};
              held_d  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = row_rot;
          end
        end
      end

      DEBOUNCE: begin
        if (sample) begin
          if (cls == PAT_ONE && col_idx == cand_q) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              state_d = ACCEPT;
              code_d  = {row_idx, cand_q};
              held_d  = 1'b1;
            end
          end else begin
            deb_d   = '0;
            row_d   = row_rot;
            state_d = SCAN;
          end
        end
      end

      ACCEPT: begin
        deb_d   = '0;
        held_d  = 1'b1;
        state_d = HELD;
      end

      HELD: begin
        if (sample) begin
          if (cls == PAT_NONE) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              deb_d   = '0;
              held_d  = 1'b0;
              row_d   = row_rot;
              state_d = SCAN;
            end
          end else begin
            deb_d = '0;
          end
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      row_q   <= ROW_INIT;
      cand_q  <= 2'd0;
      deb_q   <= '0;
      code_q  <= 4'd0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      code_q  <= code_d;
      held_q  <= held_d;
      multi_q <= multi_d;
    end
  end

  assign row_sweep = row_q;
  assign key_code  = code_q;
  assign key_held  = held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: matrix keypad model plus key_code scoreboard.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] column_in;
  logic [3:0] row_sweep;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_key;

  logic [15:0] keys;
  logic        use_model;
  logic [3:0]  col_force;
  logic [3:0]  model_cols;

  int checks = 0;
  int fails  = 0;
  int vcnt   = 0;
  logic [3:0] sb[$];

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .column_in (column_in),
    .row_sweep (row_sweep),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    model_cols = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!row_sweep[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) model_cols[c] = 1'b0;
  end
  assign column_in = use_model ? model_cols : col_force;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      logic [3:0] exp;
      vcnt++;
      checks++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_valid: observed key_code %0h, required no strobe", key_code);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checks++;
        assert (key_code === exp) else begin
          fails++;
          $error("FAIL sb_key_code: observed %0h required %0h", key_code, exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench just after a reset edge with rst low: the next edge is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int bound, output int n);
    n = 0;
    while (key_valid !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    chk(tag, key_valid, 1'b1);
  endtask

  initial begin
    int n;
    logic [3:0] e;
    keys = '0; use_model = 1'b0; col_force = 4'b0000; rst = 1'b1;

    // 1: reset values with all columns low, then free sweep
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_row", row_sweep, 4'b1110);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_held", key_held, 1'b0);
      chk("rst_multi", multi_key, 1'b0);
      chk("rst_code", key_code, 4'd0);
    end
    col_force = 4'b1111;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      e = ~(4'(1) << (((k + 1) / 4) % 4));
      chk("sweep_row", row_sweep, e);
    end

    // 2: single press of row 2 col 1
    use_model = 1'b1;
    keys = '0; keys[9] = 1'b1;
    do_reset();
    sb.push_back(4'd9);
    tick(16);                                // after edge 15
    chk("deb_row_frozen", row_sweep, 4'b1011);
    tick(3);                                 // after edge 18
    chk("press_valid_early", key_valid, 1'b0);
    tick(1);                                 // after edge 19
    chk("press_valid", key_valid, 1'b1);
    chk("press_code", key_code, 4'd9);
    chk("press_held", key_held, 1'b1);
    tick(1);                                 // after edge 20
    chk("press_valid_one_cycle", key_valid, 1'b0);
    tick(200);                               // after edge 220
    chk("hold_no_repeat", vcnt, 1);
    chk("hold_held", key_held, 1'b1);

    // 3: release, then press again
    keys = '0;
    tick(10);                                // after edge 230
    chk("release_held_still", key_held, 1'b1);
    tick(1);                                 // after edge 231
    chk("release_held_drop", key_held, 1'b0);
    chk("release_row3", row_sweep, 4'b0111);
    chk("release_code_kept", key_code, 4'd9);
    keys[9] = 1'b1;
    sb.push_back(4'd9);
    wait_valid("repress_timeout", 60, n);

    // 4: bounce on row 0 col 3
    keys = '0; keys[3] = 1'b1;
    do_reset();
    tick(8);                                 // after edge 7, two matching samples
    chk("bounce_row_frozen", row_sweep, 4'b1110);
    keys = '0;
    tick(4);                                 // after edge 11, gap sample
    chk("bounce_row_adv", row_sweep, 4'b1101);
    chk("bounce_no_valid", key_valid, 1'b0);
    keys[3] = 1'b1;
    sb.push_back(4'd3);
    wait_valid("bounce_timeout", 40, n);
    chk("bounce_latency", n, 24);

    // 5: two columns on row 1, then one released
    keys = '0; keys[4] = 1'b1; keys[6] = 1'b1;
    do_reset();
    tick(8);                                 // after edge 7
    chk("multi_set", multi_key, 1'b1);
    chk("multi_row_adv", row_sweep, 4'b1011);
    tick(1);
    chk("multi_held_between", multi_key, 1'b1);
    tick(3);                                 // after edge 11
    chk("multi_clear", multi_key, 1'b0);
    chk("multi_row3", row_sweep, 4'b0111);
    keys[6] = 1'b0;
    sb.push_back(4'd4);
    wait_valid("multi_press_timeout", 40, n);
    chk("multi_press_latency", n, 20);

    // 6: reset while debouncing with deb_cnt=2
    keys = '0; keys[0] = 1'b1;
    do_reset();
    tick(9);                                 // after edge 8
    rst = 1'b1;
    tick(1);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_row", row_sweep, 4'b1110);
    chk("mid_rst_held", key_held, 1'b0);
    keys = '0;
    rst = 1'b0;
    tick(3);
    chk("restart_row0", row_sweep, 4'b1110);
    tick(1);
    chk("restart_row1", row_sweep, 4'b1101);
    tick(4);

    chk("sb_empty", sb.size(), 0);
    chk("valid_total", vcnt, 4);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
